// File: rtl/mult_exec_stage.sv
// Multi-cycle shift-add multiply (MUL) / multiply-accumulate (MLA) execute stage.
// The result is held on the write-back port until the async handshake acknowledges it.
module mult_exec_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  rm,
    input  logic [WIDTH-1:0]  rs,
    input  logic [WIDTH-1:0]  rn,
    input  logic              accumulate,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              busy,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [WIDTH-1:0]  write_data,
    output logic              req,
    input  logic              ack,
    output logic              flag_n,
    output logic              flag_z,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, MUL, ACC, WB} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   rm_sh, rs_sh, rn_q, product, product_nx;
    logic               acc_q;
    logic [ADDR_W-1:0]  dest_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        product_nx = product;
        case (state)
            IDLE: if (start) begin
                product_nx = '0;
                if (rs != '0)      state_nx = MUL;
                else if (accumulate) state_nx = ACC;
                else               state_nx = WB;
            end
            MUL: begin
                if (rs_sh[0]) product_nx = product + rm_sh;
                // Last cycle is the one whose shifted multiplier runs out of set bits.
                if ((rs_sh >> 1) == '0) state_nx = acc_q ? ACC : WB;
            end
            ACC: begin
                product_nx = product + rn_q;
                state_nx   = WB;
            end
            WB: if (ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign write_enable = (state == WB);
    assign req          = (state == WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rm_sh         <= '0;
            rs_sh         <= '0;
            rn_q          <= '0;
            acc_q         <= 1'b0;
            dest_q        <= '0;
            product       <= '0;
            write_data    <= '0;
            write_address <= '0;
            flag_n        <= 1'b0;
            flag_z        <= 1'b0;
            done          <= 1'b0;
        end else begin
            product <= product_nx;
            done    <= (state == WB) && ack;
            if (state == IDLE && start) begin
                rm_sh  <= rm;
                rs_sh  <= rs;
                rn_q   <= rn;
                acc_q  <= accumulate;
                dest_q <= dest_addr;
            end else if (state == MUL) begin
                rm_sh <= rm_sh << 1;
                rs_sh <= rs_sh >> 1;
            end
            // Result registers load once, on the edge entering WB, so they stay put while waiting for ack.
            if (state != WB && state_nx == WB) begin
                write_data    <= product_nx;
                write_address <= (state == IDLE) ? dest_addr : dest_q;
                flag_n        <= product_nx[WIDTH-1];
                flag_z        <= (product_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_mult_exec_stage.sv
// Randomized and directed bench for mult_exec_stage against an arithmetic reference model.
module tb_mult_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] rm, rs, rn;
    logic        accumulate;
    logic [3:0]  dest_addr;
    logic        busy, write_enable, req, ack, flag_n, flag_z, done;
    logic [3:0]  write_address;
    logic [31:0] write_data;

    int n_chk  = 0;
    int n_fail = 0;

    mult_exec_stage #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rm(rm), .rs(rs), .rn(rn),
        .accumulate(accumulate), .dest_addr(dest_addr), .busy(busy),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .req(req), .ack(ack), .flag_n(flag_n),
        .flag_z(flag_z), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mul_cycles(input logic [31:0] b);
        int k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, write_enable, 0);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fn"}, flag_n, 0);
        chk({tag, "_fz"}, flag_z, 0);
        chk({tag, "_wd"}, write_data, 0);
        chk({tag, "_wa"}, write_address, 0);
    endtask

    // Called on a negedge; returns on the negedge after done has dropped.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, input logic [3:0] d, input int ack_dly,
                          input logic poke_start, input logic rand_ack);
        logic [31:0] exp_res;
        int          exp_lat, lat;
        exp_res = a * b + (acc ? c : 32'd0);
        exp_lat = mul_cycles(b) + int'(acc) + 1;
        rm = a; rs = b; rn = c; accumulate = acc; dest_addr = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        // Garbage inputs while busy must not disturb the latched operands.
        rm = $urandom; rs = $urandom; rn = $urandom; dest_addr = 4'($urandom);
        while (!write_enable && lat < 100) begin
            chk("busy_run", busy, 1);
            if (rand_ack) ack = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        ack = 1'b0;
        chk("latency", lat, exp_lat);
        chk("wdata", write_data, exp_res);
        chk("waddr", write_address, d);
        chk("flag_n", flag_n, exp_res[31]);
        chk("flag_z", flag_z, exp_res == 0);
        chk("req", req, 1);
        for (int i = 0; i < ack_dly; i++) begin
            if (poke_start) begin
                start = 1'b1; rm = $urandom; rs = $urandom; accumulate = 1'($urandom);
            end
            @(negedge clk);
            chk("hold_we", write_enable, 1);
            chk("hold_req", req, 1);
            chk("hold_wd", write_data, exp_res);
            chk("hold_wa", write_address, d);
            chk("hold_done", done, 0);
        end
        start = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_we", write_enable, 0);
        chk("done_req", req, 0);
        chk("done_busy", busy, 0);
        @(negedge clk);
        chk("done_low", done, 0);
    endtask

    initial begin
        logic [31:0] a, b, c;
        rst = 1'b1; start = 1'b0; ack = 1'b0; accumulate = 1'b0;
        rm = '0; rs = '0; rn = '0; dest_addr = '0;
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd2, 32'd2, 32'd0, 1'b0, 4'd2, 0, 1'b0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'd5, 1, 1'b0, 1'b0);
        run_op(32'd3, 32'd5, 32'd7, 1'b1, 4'd9, 0, 1'b0, 1'b0);
        run_op(32'd123, 32'd0, 32'h8000_0000, 1'b1, 4'd1, 2, 1'b0, 1'b0);
        run_op(32'd99, 32'd0, 32'd55, 1'b0, 4'd3, 0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'd15, 1, 1'b0, 1'b1);
        run_op(32'd6, 32'd7, 32'd0, 1'b0, 4'd4, 4, 1'b1, 1'b0);

        // Reset in the third MUL cycle abandons the op asynchronously.
        rm = 32'd7; rs = 32'hFF; accumulate = 1'b0; dest_addr = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_idle_zero("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_we", write_enable, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd4, 32'd3, 32'd0, 1'b0, 4'd8, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            c = $urandom;
            run_op(a, b, c, 1'($urandom), 4'($urandom), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_exec_stage.md
MULT_EXEC_STAGE -- requirements
Module: mult_exec_stage

Interface
REQ-001 Parameter WIDTH, default 32: operand, product and write-data width.
REQ-002 Parameter ADDR_W, default 4: register-file address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock; all state changes on clk.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request a multiply; sampled only in IDLE.
REQ-007 rm  input  WIDTH  multiplicand from register-file read port 1.
REQ-008 rs  input  WIDTH  multiplier from register-file read port 2.
REQ-009 rn  input  WIDTH  accumulate operand.
REQ-010 accumulate  input  1  1 = MLA (rm*rs+rn); 0 = MUL (rm*rs).
REQ-011 dest_addr  input  ADDR_W  destination register.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 write_enable  output  1  register-file write strobe.
REQ-014 write_address  output  ADDR_W  latched dest_addr.
REQ-015 write_data  output  WIDTH  result.
REQ-016 req  output  1  write-back request to the async_clk handshake.
REQ-017 ack  input  1  write-back acknowledge.
REQ-018 flag_n  output  1  result[WIDTH-1], valid with write_enable.
REQ-019 flag_z  output  1  result == 0, valid with write_enable.
REQ-020 done  output  1  one-cycle pulse on write-back completion.

Function
REQ-021 States SHALL be IDLE, MUL, ACC and WB; encoding is free.
REQ-022 IDLE with start=1: latch rm, rs, rn, accumulate and dest_addr; clear the product.
REQ-023 The start transition SHALL go to MUL if rs!=0; else to ACC if accumulate=1; else to WB.
REQ-024 Each MUL cycle: if rs_sh[0], product += rm_sh (mod 2^WIDTH); rm_sh <<= 1; rs_sh >>= 1.
REQ-025 MUL SHALL exit when the shifted rs_sh becomes 0, giving k = msb_index(rs)+1 cycles (1..WIDTH).
REQ-026 MUL SHALL exit to ACC if accumulate=1, else to WB.
REQ-027 ACC SHALL be one cycle: product += rn (mod 2^WIDTH), then go to WB.
REQ-028 All arithmetic SHALL keep only the low WIDTH bits; overflow is silently discarded.
REQ-029 On entering WB, write_data, write_address, flag_n and flag_z SHALL become valid, with write_enable=1 and req=1.
REQ-030 In WB, outputs SHALL be held stable until ack=1 is sampled on a rising clk edge.
REQ-031 On that edge: write_enable=0, req=0, done=1 for one cycle, and the state goes to IDLE.
REQ-032 start in the done cycle SHALL be accepted, since the block is in IDLE.
REQ-033 start while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-034 ack outside WB SHALL be ignored.
REQ-035 Latency from the start edge to the first WB cycle SHALL be k + accumulate + 1 cycles, where k=0 if rs=0.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, with busy, write_enable, req, done, flag_n and flag_z at 0, and write_data and write_address at 0.
REQ-037 Reset mid-MUL, mid-ACC or mid-WB SHALL abandon the operation with no write issued after rst rises.
REQ-038 The first start after rst falls SHALL behave as from a clean IDLE.

Verification
REQ-039 rm=2, rs=2, accumulate=0, dest=2, ack returned next cycle -> 2 MUL cycles, then write_data=0x00000004, write_address=2, flag_z=0, done pulse.
REQ-040 rm=0x00010000, rs=0x00010000 -> 17 MUL cycles, write_data=0x00000000, flag_z=1.
REQ-041 rm=3, rs=5, rn=7, accumulate=1 -> 3 MUL + 1 ACC cycles, write_data=0x00000016.
REQ-042 rs=0, rn=0x80000000, accumulate=1 -> MUL skipped, write_data=0x80000000, flag_n=1.
REQ-043 ack delayed 4 cycles with start pulsed during WB -> write_enable, req and data held constant, start ignored, exactly one done pulse.
REQ-044 rst asserted in the 3rd MUL cycle of rm=7, rs=0xFF -> all outputs 0 asynchronously, no write_enable; next start rm=4, rs=3 -> write_data=0x0000000C.
